// File: rtl/ff_vector_seq.sv
// ff_vector_seq: plays a host-loaded vector table into the force-format
// output register (DATA, FF, CLK_ENABLE), one vector per clock, no gaps.
// Table entry layout: {rpt[RPT_W-1:0], ff[1:0], data}; a vector is held rpt+1 cycles.
// Optional feature macro: FF_VECTOR_SEQ_LOOP_EN enables replay from entry 0 after LAST.
module ff_vector_seq #(
    parameter int ADDR_W = 6,
    parameter int RPT_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wrEn,
    input  logic [ADDR_W-1:0]   i_wrAddr,
    input  logic [RPT_W+2:0]    i_wrData,
    output logic                o_wrRej,
    input  logic [ADDR_W-1:0]   i_last,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_loop,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_seqData,
    output logic [1:0]          o_seqFf,
    output logic                o_seqCe
);

    localparam int W     = RPT_W + 3;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RUN
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [W-1:0]        r_mem [DEPTH];
    logic [W-1:0]        r_rdData;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_pfAddr;
    logic [ADDR_W-1:0]   r_lastQ;
    logic [ADDR_W-1:0]   w_rdAddr;
    logic [ADDR_W-1:0]   w_pfNext;
    logic [RPT_W-1:0]    r_rptCnt;
    logic                r_stopPend;
    logic                r_done;
    logic                r_wrRej;
    logic                r_seqData;
    logic [1:0]          r_seqFf;
    logic                r_seqCe;
    logic                w_loopQ;
    logic                w_load;
    logic                w_finish;
    logic                w_boundary;
    logic                w_atLast;
    logic                w_stopNow;

`ifdef FF_VECTOR_SEQ_LOOP_EN
    logic r_loopQ;

    // Capture the loop request at START so it stays stable for the whole run
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_loopQ <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_loopQ <= i_loop;
        end
    end

    assign w_loopQ  = r_loopQ;
    assign w_pfNext = (r_pfAddr == r_lastQ) ? '0 : r_pfAddr + 1'b1;
`else
    logic w_unusedLoop;

    assign w_unusedLoop = i_loop;
    assign w_loopQ      = 1'b0;
    assign w_pfNext     = r_pfAddr + 1'b1;
`endif

    assign w_boundary = (r_rptCnt == '0);
    assign w_atLast   = (r_addr == r_lastQ);
    assign w_stopNow  = r_stopPend | i_stop;

    // Table RAM: host writes only while idle, registered read every cycle
    always_ff @(posedge i_clk) begin
        if (i_wrEn && r_state == S_IDLE) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        r_rdData <= r_mem[w_rdAddr];
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; read address always points one entry ahead of the outputs
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_rdAddr    = r_pfAddr;
        case (r_state)
            S_IDLE: begin
                w_rdAddr = '0;
                if (i_start) begin
                    w_stateNext = S_FETCH;
                end
            end
            S_FETCH: begin
                w_load      = 1'b1;
                w_rdAddr    = w_pfNext;
                w_stateNext = S_RUN;
            end
            S_RUN: begin
                if (w_boundary) begin
                    if (w_stopNow || (w_atLast && !w_loopQ)) begin
                        w_finish    = 1'b1;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_load   = 1'b1;
                        w_rdAddr = w_pfNext;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Datapath: output vector, repeat counter, prefetch address and status pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_pfAddr   <= '0;
            r_lastQ    <= '0;
            r_rptCnt   <= '0;
            r_stopPend <= 1'b0;
            r_done     <= 1'b0;
            r_wrRej    <= 1'b0;
            r_seqData  <= 1'b0;
            r_seqFf    <= 2'b00;
            r_seqCe    <= 1'b0;
        end else begin
            r_done  <= w_finish;
            r_wrRej <= i_wrEn && (r_state != S_IDLE);
            if (r_state == S_IDLE) begin
                r_stopPend <= 1'b0;
            end else if (i_stop) begin
                r_stopPend <= 1'b1;
            end
            if (r_state == S_IDLE && i_start) begin
                r_lastQ  <= i_last;
                r_pfAddr <= '0;
            end
            if (w_load) begin
                r_seqData <= r_rdData[0];
                r_seqFf   <= r_rdData[2:1];
                r_rptCnt  <= r_rdData[W-1:3];
                r_seqCe   <= 1'b1;
                r_addr    <= r_pfAddr;
                r_pfAddr  <= w_pfNext;
            end else if (w_finish) begin
                r_seqCe <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_rptCnt <= r_rptCnt - 1'b1;
            end
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_wrRej   = r_wrRej;
    assign o_seqData = r_seqData;
    assign o_seqFf   = r_seqFf;
    assign o_seqCe   = r_seqCe;

endmodule

// File: tb/tb_ff_vector_seq.sv
// Directed bench for ff_vector_seq: reset, basic run, stop, loop, protocol abuse,
// full-table addressing, long repeat and reset mid-run.
module tb_ff_vector_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [5:0]  wrAddr;
    logic [10:0] wrData;
    logic        wrRej;
    logic [5:0]  last;
    logic        start;
    logic        stop;
    logic        loopIn;
    logic        busy;
    logic        done;
    logic        seqData;
    logic [1:0]  seqFf;
    logic        seqCe;

    int errors = 0;
    int checks = 0;
    logic [10:0] model [64];

    ff_vector_seq #(.ADDR_W(6), .RPT_W(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wrEn    (wrEn),
        .i_wrAddr  (wrAddr),
        .i_wrData  (wrData),
        .o_wrRej   (wrRej),
        .i_last    (last),
        .i_start   (start),
        .i_stop    (stop),
        .i_loop    (loopIn),
        .o_busy    (busy),
        .o_done    (done),
        .o_seqData (seqData),
        .o_seqFf   (seqFf),
        .o_seqCe   (seqCe)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic writeEntry(input logic [5:0] a, input logic [10:0] d);
        wrEn   = 1'b1;
        wrAddr = a;
        wrData = d;
        tick();
        wrEn = 1'b0;
        checkOutput("wr_rej_idle", 16'(wrRej), 16'd0);
        model[a] = d;
    endtask

    task automatic applyStimulus(input logic [5:0] lastIdx, input logic lp);
        last   = lastIdx;
        loopIn = lp;
        start  = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_busy", 16'(busy), 16'd1);
        checkOutput("start_ce", 16'(seqCe), 16'd0);
    endtask

    task automatic checkVector(input logic d, input logic [1:0] ff, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput("vec_ce", 16'(seqCe), 16'd1);
            checkOutput("vec_data", 16'(seqData), 16'(d));
            checkOutput("vec_ff", 16'(seqFf), 16'(ff));
            checkOutput("vec_done", 16'(done), 16'd0);
        end
    endtask

    task automatic checkEnd(input logic d, input logic [1:0] ff);
        tick();
        checkOutput("end_ce", 16'(seqCe), 16'd0);
        checkOutput("end_busy", 16'(busy), 16'd0);
        checkOutput("end_done", 16'(done), 16'd1);
        checkOutput("end_data", 16'(seqData), 16'(d));
        checkOutput("end_ff", 16'(seqFf), 16'(ff));
    endtask

    task automatic playBasic();
        checkVector(1'b1, 2'b10, 1);
        checkVector(1'b0, 2'b11, 3);
        checkVector(1'b1, 2'b01, 1);
    endtask

    // Directed test sequence
    initial begin
        int cnt;
        rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0;
        last = '0; start = 1'b0; stop = 1'b0; loopIn = 1'b0;
        tick();
        tick();
        checkOutput("rst_ce", 16'(seqCe), 16'd0);
        checkOutput("rst_ff", 16'(seqFf), 16'd0);
        checkOutput("rst_data", 16'(seqData), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_wrrej", 16'(wrRej), 16'd0);
        rst = 1'b0;

        writeEntry(6'd0, 11'd5);
        writeEntry(6'd1, 11'd22);
        writeEntry(6'd2, 11'd3);
        writeEntry(6'd3, 11'd8);

        $display("[TB] basic run");
        applyStimulus(6'd2, 1'b0);
        playBasic();
        checkEnd(1'b1, 2'b01);
        tick();
        checkOutput("done_pulse_width", 16'(done), 16'd0);

        $display("[TB] write and start during run");
        applyStimulus(6'd2, 1'b0);
        checkVector(1'b1, 2'b10, 1);
        wrEn = 1'b1; wrAddr = 6'd0; wrData = 11'd0;
        start = 1'b1; last = 6'd0;
        checkVector(1'b0, 2'b11, 1);
        wrEn = 1'b0; start = 1'b0;
        checkOutput("wr_rej_pulse", 16'(wrRej), 16'd1);
        checkVector(1'b0, 2'b11, 1);
        checkOutput("wr_rej_clear", 16'(wrRej), 16'd0);
        checkVector(1'b0, 2'b11, 1);
        checkVector(1'b1, 2'b01, 1);
        checkEnd(1'b1, 2'b01);
        applyStimulus(6'd0, 1'b0);
        checkVector(1'b1, 2'b10, 1);
        checkEnd(1'b1, 2'b10);

        $display("[TB] stop during held vector");
        applyStimulus(6'd2, 1'b1);
        checkVector(1'b1, 2'b10, 1);
        checkVector(1'b0, 2'b11, 1);
        stop = 1'b1;
        checkVector(1'b0, 2'b11, 1);
        stop = 1'b0;
        checkVector(1'b0, 2'b11, 1);
        checkEnd(1'b0, 2'b11);

        $display("[TB] loop request");
        applyStimulus(6'd2, 1'b1);
`ifdef FF_VECTOR_SEQ_LOOP_EN
        playBasic();
        playBasic();
        stop = 1'b1;
        checkEnd(1'b1, 2'b01);
        stop = 1'b0;
`else
        playBasic();
        checkEnd(1'b1, 2'b01);
`endif

        $display("[TB] full table");
        for (int a = 4; a < 64; a++) begin
            logic [5:0] av;
            av = 6'(a);
            writeEntry(av, {8'd0, av[1:0], av[2]});
        end
`ifdef FF_VECTOR_SEQ_LOOP_EN
        applyStimulus(6'd63, 1'b1);
`else
        applyStimulus(6'd63, 1'b0);
`endif
        for (int a = 0; a < 64; a++) begin
            logic [10:0] e;
            e = model[a];
            checkVector(e[0], e[2:1], int'(e[10:3]) + 1);
        end
`ifdef FF_VECTOR_SEQ_LOOP_EN
        checkVector(1'b1, 2'b10, 1);
        stop = 1'b1;
        checkEnd(1'b1, 2'b10);
        stop = 1'b0;
`else
        checkEnd(1'b1, 2'b11);
`endif

        $display("[TB] single vector, rpt=255");
        writeEntry(6'd0, 11'd2047);
        applyStimulus(6'd0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!seqCe) break;
            cnt++;
        end
        checkOutput("long_ce_cycles", 16'(cnt), 16'd256);
        checkOutput("long_done", 16'(done), 16'd1);
        checkOutput("long_ff", 16'(seqFf), 16'd3);
        checkOutput("long_data", 16'(seqData), 16'd1);

        $display("[TB] reset mid-vector");
        applyStimulus(6'd0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("mid_ce", 16'(seqCe), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst_ce", 16'(seqCe), 16'd0);
        checkOutput("mrst_busy", 16'(busy), 16'd0);
        checkOutput("mrst_done", 16'(done), 16'd0);
        checkOutput("mrst_ff", 16'(seqFf), 16'd0);
        checkOutput("mrst_data", 16'(seqData), 16'd0);
        tick();
        checkOutput("mrst_no_done", 16'(done), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ff_vector_seq.md
# ff_vector_seq

Vector sequencer that drives the force-format output register. It plays a host-loaded table of vectors into the register's DATA, FF and CLK_ENABLE inputs, one vector per clock with no gaps. Each vector carries a data bit, a 2-bit format code and a repeat count. The block sits between the host/config bus and the force-format output register, in the same clock domain as that register.

## Interface
- `ADDR_W`, 6: vector table address width; depth = 2^ADDR_W.
- `RPT_W`, 8: repeat-count width; a vector is held for rpt+1 cycles.
- `CLK` in 1: clock; also clocks the force-format register.
- `RST` in 1: synchronous, active-high reset.
- `WR_EN` in 1: table write strobe.
- `WR_ADDR` in ADDR_W: table write address.
- `WR_DATA` in 3+RPT_W: entry {rpt[RPT_W-1:0], ff[1:0], data}; data is bit 0.
- `WR_REJ` out 1: one-cycle pulse when a write is dropped because BUSY=1.
- `LAST` in ADDR_W: index of the final vector; sampled on START.
- `START` in 1: one-cycle start request; honoured only in IDLE.
- `STOP` in 1: one-cycle stop request; takes effect at the next vector boundary.
- `LOOP` in 1: replay from entry 0 after LAST; sampled on START (see Configuration).
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse on return to IDLE.
- `SEQ_DATA` out 1: to the register's DATA.
- `SEQ_FF` out 2: to the register's FF.
- `SEQ_CE` out 1: to the register's CLK_ENABLE.

## Operation
- Vector table: 2^ADDR_W x (3+RPT_W) RAM with a registered read.
  - Written only in IDLE. Writes while BUSY are dropped and pulse WR_REJ.
  - Contents survive RST.
- FSM states and transitions:
  - IDLE: on START, latch LAST and LOOP into last_q/loop_q, read entry 0, go to FETCH.
  - FETCH (1 cycle): load entry 0 into the output registers and rpt_cnt, issue the read of entry 1, go to RUN.
  - RUN: while rpt_cnt != 0, decrement and hold the outputs. When rpt_cnt == 0 (vector boundary):
    - If STOP is pending, go to IDLE.
    - Else if addr == last_q and loop_q=0, go to IDLE.
    - Else if addr == last_q and loop_q=1, load entry 0; the next entry is always prefetched, so there is no bubble.
    - Else load entry addr+1.
- STOP is latched into stop_pend on any cycle in RUN or FETCH. A STOP arriving on the boundary cycle itself stops at that boundary. stop_pend clears in IDLE.
- START while BUSY: ignored.
- START and STOP in the same cycle in IDLE: START is honoured and STOP is ignored.
- Addressing: addr wraps modulo 2^ADDR_W. LAST = 2^ADDR_W-1 plays the full table. LAST=0 plays a single vector.
- SEQ_FF, SEQ_DATA and SEQ_CE change only at vector boundaries. They are registered outputs with no combinational path from any input.
- On entry to IDLE:
  - SEQ_CE=0; SEQ_FF and SEQ_DATA hold the last vector's values.
  - DONE pulses on the transition cycle.

## Timing
- Reset values: SEQ_DATA=0, SEQ_FF=2'b00, SEQ_CE=0, BUSY=0, DONE=0, WR_REJ=0. State=IDLE, addr=0, rpt_cnt=0, stop_pend=0.
- RST asserted mid-run: next cycle is IDLE with reset output values. No DONE pulse.
- START at cycle t: BUSY=1 at t+1. The first vector is on the outputs with SEQ_CE=1 from t+2.
- Vector i with rpt=r occupies exactly r+1 consecutive cycles. Vector i+1 follows on the very next cycle, including the LAST->0 wrap.
- Normal end: the last vector's final cycle is c. At c+1: SEQ_CE=0, BUSY=0, DONE=1.
- WR_REJ: asserted the cycle after the rejected WR_EN.
- Table write at cycle t: readable by a START at t+1 or later.

## Configuration
- `FF_VECTOR_SEQ_LOOP_EN` defined: LOOP input is functional as described in Operation.
- Not defined: LOOP is ignored, loop_q is tied to 0, every run ends after LAST, and the wrap-prefetch logic is removed.

## Test plan
- Reset check: assert RST for 2 cycles -> all outputs at their reset values; table writes of 0..3 are accepted with WR_REJ=0.
- Basic run: table {d=1,ff=10,rpt=0}, {d=0,ff=11,rpt=2}, {d=1,ff=01,rpt=0}, LAST=2, START at t:
  - SEQ_CE=1 over t+2..t+6.
  - SEQ_FF/SEQ_DATA = 10/1, then 11/0 x3, then 01/1.
  - DONE and SEQ_CE=0 at t+7.
- Loop (macro defined): same table, LOOP=1 -> the 5-cycle pattern repeats with no gap. STOP during the rpt=2 vector -> that vector finishes, then IDLE and DONE.
- Boundary cases:
  - LAST=0, rpt=255 -> exactly 256 cycles of SEQ_CE=1.
  - ADDR_W=2, LAST=3 with loop -> addr wraps 3->0 gapless.
- Protocol abuse:
  - WR_EN during a run -> WR_REJ pulse and the table is unchanged.
  - START during a run -> no effect.
  - RST mid-vector -> outputs at reset values next cycle, no DONE pulse.
